noc_tx_arb: RTL and testbench

//  Shares the single outbound NoC byte link (noc_from_dev_ctl/noc_from_dev_data) between NSRC packet sources.

---
 rtl/noc_pkg.sv | 16 +
 rtl/noc_rr_pick.sv | 50 +++++
 rtl/noc_tx_arb.sv | 145 ++++++++++++++
 tb/tb_noc_tx_arb.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC link constants and the outbound arbiter state type.
package noc_pkg;

    localparam logic [7:0] NOC_NOP_DATA  = 8'h00;

    // Header opcodes carried in the first byte of a packet.
    localparam logic [2:0] NOC_OP_WR_REQ = 3'b010;
    localparam logic [2:0] NOC_OP_WR_RSP = 3'b011;
    localparam logic [2:0] NOC_OP_RD_RSP = 3'b101;

    typedef enum logic {
        ARB_IDLE,
        ARB_PKT
    } arb_state_t;

endpackage

// File: rtl/noc_rr_pick.sv
// Combinational winner picker for the outbound link arbiter.
// Round-robin after `last` by default; NOC_TX_ARB_FIXED_PRIO_EN selects lowest-index priority.
module noc_rr_pick
    import noc_pkg::*;
#(
    parameter int NSRC = 2
) (
    input  logic [NSRC-1:0] req,
    input  logic [2:0]      last,
    output logic [NSRC-1:0] gnt,
    output logic [2:0]      gnt_idx,
    output logic            any
);

    assign any = |req;

`ifdef NOC_TX_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = ^last;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        gnt     = '0;
        gnt_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt     = '0;
                gnt[i]  = 1'b1;
                gnt_idx = 3'(i);
            end
        end
    end
`else
    // Offsets are scanned far-to-near so the nearest requester after `last` is written last and wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        for (int off = NSRC; off >= 1; off--) begin
            for (int i = 0; i < NSRC; i++) begin
                if (req[i] && ((int'(last) + off) % NSRC == i)) begin
                    gnt     = '0;
                    gnt[i]  = 1'b1;
                    gnt_idx = 3'(i);
                end
            end
        end
    end
`endif

endmodule

// File: rtl/noc_tx_arb.sv
// Packet-atomic arbiter sharing the outbound NoC byte link between NSRC sources.
// Define NOC_TX_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module noc_tx_arb
    import noc_pkg::*;
#(
    parameter int NSRC        = 2,
    parameter int MAX_PKT_LEN = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NSRC-1:0]   src_valid,
    input  logic [NSRC*8-1:0] src_data,
    input  logic [NSRC-1:0]   src_last,
    output logic [NSRC-1:0]   src_ready,
    output logic              noc_from_dev_ctl,
    output logic [7:0]        noc_from_dev_data,
    output logic              busy,
    output logic [2:0]        gnt_id,
    output logic              err_bubble,
    output logic              err_len
);

    localparam int               CNT_W   = $clog2(MAX_PKT_LEN + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PKT_LEN);

    arb_state_t       state_q, state_d;
    logic [2:0]       gnt_q, gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             gap_q, gap_d;
    logic             ctl_q, ctl_d;
    logic [7:0]       data_q, data_d;
    logic             err_bubble_q, err_bubble_d;
    logic             err_len_q, err_len_d;

    logic [NSRC-1:0]  pick_gnt;
    logic [2:0]       pick_idx;
    logic             pick_any;
    logic [7:0]       pick_byte, sel_byte;
    logic             pick_last, sel_valid, sel_last;

    noc_rr_pick #(.NSRC(NSRC)) u_pick (
        .req     (src_valid),
        .last    (gnt_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // Byte/last of the fresh winner (IDLE) and of the current owner (PKT).
    always_comb begin
        pick_byte = '0;
        pick_last = 1'b0;
        sel_byte  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (pick_gnt[i]) begin
                pick_byte = src_data[8*i +: 8];
                pick_last = src_last[i];
            end
            if (gnt_q == 3'(i)) begin
                sel_byte  = src_data[8*i +: 8];
                sel_valid = src_valid[i];
                sel_last  = src_last[i];
            end
        end
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    // gap_q holds off arbitration for one cycle after a packet ends so a single NOP separates packets.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        cnt_d        = cnt_q;
        gap_d        = 1'b0;
        ctl_d        = 1'b1;
        data_d       = NOC_NOP_DATA;
        err_bubble_d = 1'b0;
        err_len_d    = 1'b0;
        src_ready    = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (!gap_q && pick_any) begin
                    src_ready = pick_gnt;
                    data_d    = pick_byte;
                    gnt_d     = pick_idx;
                    cnt_d     = CNT_W'(1);
                    if (pick_last) gap_d   = 1'b1;
                    else           state_d = ARB_PKT;
                end
            end
            ARB_PKT: begin
                if (sel_valid) begin
                    for (int i = 0; i < NSRC; i++) src_ready[i] = (gnt_q == 3'(i));
                    ctl_d  = 1'b0;
                    data_d = sel_byte;
                    cnt_d  = cnt_inc;
                    if (sel_last) begin
                        state_d = ARB_IDLE;
                        gap_d   = 1'b1;
                    end else if (cnt_inc == MAX_CNT) begin
                        state_d   = ARB_IDLE;
                        gap_d     = 1'b1;
                        err_len_d = 1'b1;
                    end
                end else begin
                    err_bubble_d = 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            gnt_q        <= 3'(NSRC - 1);
            cnt_q        <= '0;
            gap_q        <= 1'b0;
            ctl_q        <= 1'b1;
            data_q       <= NOC_NOP_DATA;
            err_bubble_q <= 1'b0;
            err_len_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            ctl_q        <= ctl_d;
            data_q       <= data_d;
            err_bubble_q <= err_bubble_d;
            err_len_q    <= err_len_d;
        end
    end

    assign noc_from_dev_ctl  = ctl_q;
    assign noc_from_dev_data = data_q;
    assign busy              = (state_q == ARB_PKT);
    assign gnt_id            = gnt_q;
    assign err_bubble        = err_bubble_q;
    assign err_len           = err_len_q;

endmodule

// File: tb/tb_noc_tx_arb.sv
// Self-checking bench for noc_tx_arb: directed vector table, directed sequences and randomized traffic.
module tb_noc_tx_arb;
    import noc_pkg::*;

    localparam int NSRC = 2;
    localparam int MAXL = 40;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NSRC-1:0]   src_valid = '0;
    logic [NSRC*8-1:0] src_data = '0;
    logic [NSRC-1:0]   src_last = '0;
    logic [NSRC-1:0]   src_ready;
    logic              ctl;
    logic [7:0]        data;
    logic              busy;
    logic [2:0]        gnt_id;
    logic              err_bubble, err_len;

    noc_tx_arb #(.NSRC(NSRC), .MAX_PKT_LEN(MAXL)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .src_valid         (src_valid),
        .src_data          (src_data),
        .src_last          (src_last),
        .src_ready         (src_ready),
        .noc_from_dev_ctl  (ctl),
        .noc_from_dev_data (data),
        .busy              (busy),
        .gnt_id            (gnt_id),
        .err_bubble        (err_bubble),
        .err_len           (err_len)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Source streams: each entry is {last, byte}; en gates which sources offer their head byte.
    logic [8:0]      sq [NSRC][$];
    logic [NSRC-1:0] en = '0;
    logic [7:0]      hdr_log [$];
    int              el_cnt = 0;

    // Reference model: packet owner, bytes in packet, pending separator NOP, last grant.
    int   m_owner, m_cnt, m_last;
    bit   m_gap;
    logic [NSRC-1:0] e_rdy;
    logic e_ctl, e_busy, e_eb, e_el;
    logic [7:0] e_data;
    logic [2:0] e_gnt;

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_gap   = 1'b0;
        m_last  = NSRC - 1;
    endtask

    function automatic int model_pick(input logic [NSRC-1:0] v);
`ifdef NOC_TX_ARB_FIXED_PRIO_EN
        for (int k = 0; k < NSRC; k++) if (v[k]) return k;
`else
        for (int k = 1; k <= NSRC; k++) if (v[(m_last + k) % NSRC]) return (m_last + k) % NSRC;
`endif
        return -1;
    endfunction

    task automatic model_step(input logic [NSRC-1:0] v, input logic [NSRC-1:0] l,
                              input logic [NSRC*8-1:0] d);
        int w;
        e_rdy  = '0;
        e_ctl  = 1'b1;
        e_data = 8'h00;
        e_eb   = 1'b0;
        e_el   = 1'b0;
        if (m_owner < 0) begin
            if (m_gap) begin
                m_gap = 1'b0;
            end else if (v != '0) begin
                w        = model_pick(v);
                e_rdy[w] = 1'b1;
                e_data   = d[8*w +: 8];
                m_last   = w;
                m_cnt    = 1;
                if (l[w]) m_gap = 1'b1;
                else      m_owner = w;
            end
        end else if (v[m_owner]) begin
            e_rdy[m_owner] = 1'b1;
            e_ctl  = 1'b0;
            e_data = d[8*m_owner +: 8];
            m_cnt++;
            if (l[m_owner]) begin
                m_owner = -1;
                m_gap   = 1'b1;
            end else if (m_cnt == MAXL) begin
                m_owner = -1;
                m_gap   = 1'b1;
                e_el    = 1'b1;
            end
        end else begin
            e_eb = 1'b1;
        end
        e_busy = (m_owner >= 0);
        e_gnt  = 3'(m_last);
    endtask

    // One clock: drive at negedge, check pop strobes before posedge, check link after posedge.
    task automatic cycle();
        logic [NSRC-1:0]   v, l, rdy;
        logic [NSRC*8-1:0] d;
        @(negedge clk);
        v = '0; l = '0; d = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (en[i] && sq[i].size() > 0) begin
                v[i]        = 1'b1;
                d[8*i +: 8] = sq[i][0][7:0];
                l[i]        = sq[i][0][8];
            end
        end
        src_valid = v;
        src_last  = l;
        src_data  = d;
        model_step(v, l, d);
        #4;
        rdy = src_ready;
        check("src_ready", 32'(rdy), 32'(e_rdy));
        @(posedge clk);
        #1;
        for (int i = 0; i < NSRC; i++) if (rdy[i] && sq[i].size() > 0) void'(sq[i].pop_front());
        check("link_ctl", 32'(ctl), 32'(e_ctl));
        check("link_data", 32'(data), 32'(e_data));
        check("busy", 32'(busy), 32'(e_busy));
        check("gnt_id", 32'(gnt_id), 32'(e_gnt));
        check("err_bubble", 32'(err_bubble), 32'(e_eb));
        check("err_len", 32'(err_len), 32'(e_el));
        if (ctl && data != 8'h00) hdr_log.push_back(data);
        if (err_len) el_cnt++;
    endtask

    task automatic push_pkt(input int s, input int len, input logic [7:0] hdr, input bit has_last);
        for (int k = 0; k < len; k++) begin
            logic [7:0] b;
            b = (k == 0) ? hdr : 8'($urandom);
            sq[s].push_back({(has_last && k == len - 1), b});
        end
    endtask

    task automatic flush();
        for (int i = 0; i < NSRC; i++) sq[i].delete();
        hdr_log.delete();
        el_cnt = 0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_ctl"}, 32'(ctl), 32'h1);
        check({tag, "_data"}, 32'(data), 32'h00);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_gnt"}, 32'(gnt_id), 32'(NSRC - 1));
        check({tag, "_err"}, 32'({err_bubble, err_len}), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        src_valid = '0; src_last = '0; src_data = '0; en = '0;
        rst_n = 1'b0;
        flush();
        #1;
        reset_checks("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [1:0] v;
        logic [7:0] d0, d1;
        logic [1:0] l;
        logic [1:0] rdy;
        logic       ctl;
        logic [7:0] dat;
        logic       bsy;
        logic [2:0] gnt;
        logic       eb, el;
    } vec_t;

    vec_t tbl [16];

    initial begin
        tbl[0]  = '{2'b01, 8'hA2, 8'h00, 2'b00, 2'b01, 1'b1, 8'hA2, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{2'b01, 8'h11, 8'h00, 2'b00, 2'b01, 1'b0, 8'h11, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{2'b01, 8'h22, 8'h00, 2'b00, 2'b01, 1'b0, 8'h22, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[3]  = '{2'b01, 8'h33, 8'h00, 2'b01, 2'b01, 1'b0, 8'h33, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[4]  = '{2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[5]  = '{2'b10, 8'h00, 8'hB5, 2'b00, 2'b10, 1'b1, 8'hB5, 1'b1, 3'd1, 1'b0, 1'b0};
        tbl[6]  = '{2'b10, 8'h00, 8'h44, 2'b00, 2'b10, 1'b0, 8'h44, 1'b1, 3'd1, 1'b0, 1'b0};
        tbl[7]  = '{2'b01, 8'h77, 8'h00, 2'b00, 2'b00, 1'b1, 8'h00, 1'b1, 3'd1, 1'b1, 1'b0};
        tbl[8]  = '{2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b1, 8'h00, 1'b1, 3'd1, 1'b1, 1'b0};
        tbl[9]  = '{2'b10, 8'h00, 8'h55, 2'b00, 2'b10, 1'b0, 8'h55, 1'b1, 3'd1, 1'b0, 1'b0};
        tbl[10] = '{2'b10, 8'h00, 8'h66, 2'b10, 2'b10, 1'b0, 8'h66, 1'b0, 3'd1, 1'b0, 1'b0};
        tbl[11] = '{2'b11, 8'hC0, 8'hD0, 2'b11, 2'b00, 1'b1, 8'h00, 1'b0, 3'd1, 1'b0, 1'b0};
        tbl[12] = '{2'b11, 8'hC0, 8'hD0, 2'b11, 2'b01, 1'b1, 8'hC0, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[13] = '{2'b10, 8'h00, 8'hD0, 2'b10, 2'b00, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[14] = '{2'b10, 8'h00, 8'hD0, 2'b10, 2'b10, 1'b1, 8'hD0, 1'b0, 3'd1, 1'b0, 1'b0};
        tbl[15] = '{2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b1, 8'h00, 1'b0, 3'd1, 1'b0, 1'b0};

        model_reset();
        do_reset();

        // Idle link after reset.
        repeat (5) cycle();

        // 4-byte packet from src0, then src1 packet with a 2-cycle bubble, then 1-byte packets.
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            src_valid = tbl[t].v;
            src_data  = {tbl[t].d1, tbl[t].d0};
            src_last  = tbl[t].l;
            #4;
            check($sformatf("vec%0d_ready", t), 32'(src_ready), 32'(tbl[t].rdy));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_link", t), 32'({ctl, data}), 32'({tbl[t].ctl, tbl[t].dat}));
            check($sformatf("vec%0d_busy", t), 32'(busy), 32'(tbl[t].bsy));
            check($sformatf("vec%0d_gnt", t), 32'(gnt_id), 32'(tbl[t].gnt));
            check($sformatf("vec%0d_err", t), 32'({err_bubble, err_len}), 32'({tbl[t].eb, tbl[t].el}));
        end

        // Both sources with continuous 3-byte packets.
        do_reset();
        for (int p = 0; p < 4; p++) begin
            push_pkt(0, 3, 8'hA0, 1'b1);
            push_pkt(1, 3, 8'hA1, 1'b1);
        end
        en = 2'b11;
        repeat (40) cycle();
        check("alt_hdr_count", 32'(hdr_log.size()), 32'd8);
        for (int p = 0; p < 8 && p < hdr_log.size(); p++) begin
`ifdef NOC_TX_ARB_FIXED_PRIO_EN
            check($sformatf("fixed_hdr%0d", p), 32'(hdr_log[p]), (p < 4) ? 32'hA0 : 32'hA1);
`else
            check($sformatf("alt_hdr%0d", p), 32'(hdr_log[p]), (p % 2 == 0) ? 32'hA0 : 32'hA1);
`endif
        end

        // Over-long packet from src0 is force-terminated after MAXL bytes.
        do_reset();
        sq[0].push_back({1'b0, 8'hA0});
        for (int k = 1; k < 45; k++) sq[0].push_back({(k == 44), 8'(k)});
        sq[1].push_back({1'b0, 8'hA1});
        sq[1].push_back({1'b0, 8'h5A});
        sq[1].push_back({1'b1, 8'h5B});
        en = 2'b11;
        repeat (70) cycle();
        check("len_err_pulses", 32'(el_cnt), 32'd1);
        check("len_hdr_count", 32'(hdr_log.size()), 32'd3);
        if (hdr_log.size() == 3) begin
`ifdef NOC_TX_ARB_FIXED_PRIO_EN
            check("len_next_hdr", 32'(hdr_log[1]), 32'h28);
            check("len_third_hdr", 32'(hdr_log[2]), 32'hA1);
`else
            check("len_next_hdr", 32'(hdr_log[1]), 32'hA1);
            check("len_third_hdr", 32'(hdr_log[2]), 32'h28);
`endif
        end

        // Asynchronous reset in the middle of a packet.
        do_reset();
        en = 2'b01;
        push_pkt(0, 6, 8'hA0, 1'b1);
        repeat (3) cycle();
        check("pre_reset_busy", 32'(busy), 32'h1);
        @(negedge clk);
        src_valid = '0; src_last = '0; src_data = '0;
        #2 rst_n = 1'b0;
        #1;
        reset_checks("async_rst");
        flush();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        push_pkt(0, 2, 8'hA0, 1'b1);
        push_pkt(1, 2, 8'hA1, 1'b1);
        en = 2'b11;
        repeat (8) cycle();
        check("post_rst_first", (hdr_log.size() > 0) ? 32'(hdr_log[0]) : 32'hFFFF, 32'hA0);

        // Randomized traffic with random source stalls against the reference model.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NSRC; i++) begin
                en[i] = ($urandom_range(3) != 0);
                if (sq[i].size() < 3) begin
                    if ($urandom_range(19) == 0) push_pkt(i, 41 + $urandom_range(3), 8'($urandom), 1'b0);
                    else push_pkt(i, 1 + $urandom_range(7), 8'($urandom), 1'b1);
                end
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
